// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MDU op encodings, state type and width default
package mips_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } mdu_state_t;

endpackage

// File: rtl/mdu_seq_ctrl_if.sv
// rtl/mdu_seq_ctrl_if.sv - issue/result interface between pipeline and MDU
interface mdu_seq_ctrl_if #(parameter int XLEN = mips_pkg::XLEN_DEFAULT);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] rs_val;
    logic [XLEN-1:0] rt_val;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;

    modport master (output start, op, rs_val, rt_val, flush,
                    input  busy, done, hi, lo);
    modport slave  (input  start, op, rs_val, rt_val, flush,
                    output busy, done, hi, lo);
endinterface

// File: rtl/mdu_iter_step.sv
// rtl/mdu_iter_step.sv - one radix-2 shift-add or restoring shift-subtract step
module mdu_iter_step #(
    parameter int XLEN = mips_pkg::XLEN_DEFAULT
) (
    input  logic              is_div,
    input  logic [2*XLEN-1:0] acc_in,
    input  logic [XLEN-1:0]   operand,
    output logic [2*XLEN-1:0] acc_out
);
    logic [XLEN:0] sum;
    logic [XLEN:0] diff;

    // Multiply: add operand into the upper half when the next multiplier bit is set, then shift right.
    // Divide: shift left, trial-subtract the divisor from the partial remainder, keep it if non-negative.
    always_comb begin
        sum  = {1'b0, acc_in[2*XLEN-1:XLEN]} + (acc_in[0] ? {1'b0, operand} : '0);
        diff = acc_in[2*XLEN-1:XLEN-1] - {1'b0, operand};
        if (is_div) begin
            if (diff[XLEN])
                acc_out = {acc_in[2*XLEN-2:0], 1'b0};
            else
                acc_out = {diff[XLEN-1:0], acc_in[XLEN-2:0], 1'b1};
        end else begin
            acc_out = {sum, acc_in[XLEN-1:1]};
        end
    end
endmodule

// File: rtl/mdu_seq_ctrl.sv
// rtl/mdu_seq_ctrl.sv - iterative MULT/DIV sequencer owning HI/LO; option MDU_ZERO_SKIP_EN
module mdu_seq_ctrl
    import mips_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    mdu_seq_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(XLEN);

    mdu_state_t        state;
    logic [CNT_W-1:0]  count;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] acc_step;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   opb;
    logic [XLEN-1:0]   dividend;
    logic [XLEN-1:0]   hi_q;
    logic [XLEN-1:0]   lo_q;
    logic [XLEN-1:0]   res_hi;
    logic [XLEN-1:0]   res_lo;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic              is_div;
    logic              neg_res;
    logic              neg_rem;
    logic              div_zero;
    logic              done_q;
    logic              op_div;
    logic              op_signed;
    logic              sign_a;
    logic              sign_b;
    logic              skip;

    // Decode the issuing op and form operand magnitudes for the unsigned datapath.
    always_comb begin
        op_div    = (bus.op == MDU_DIV) || (bus.op == MDU_DIVU);
        op_signed = (bus.op == MDU_MULT) || (bus.op == MDU_DIV);
        sign_a    = op_signed && bus.rs_val[XLEN-1];
        sign_b    = op_signed && bus.rt_val[XLEN-1];
        mag_a     = sign_a ? ('0 - bus.rs_val) : bus.rs_val;
        mag_b     = sign_b ? ('0 - bus.rt_val) : bus.rt_val;
`ifdef MDU_ZERO_SKIP_EN
        skip      = op_div ? (bus.rt_val == '0) : ((bus.rs_val == '0) || (bus.rt_val == '0));
`else
        skip      = 1'b0;
`endif
    end

    mdu_iter_step #(.XLEN(XLEN)) u_step (
        .is_div  (is_div),
        .acc_in  (acc),
        .operand (opb),
        .acc_out (acc_step)
    );

    // Sign-correct the finished accumulator; divide by zero bypasses the datapath result.
    always_comb begin
        prod_fix = neg_res ? ('0 - acc) : acc;
        res_hi   = prod_fix[2*XLEN-1:XLEN];
        res_lo   = prod_fix[XLEN-1:0];
        if (is_div) begin
            if (div_zero) begin
                res_hi = dividend;
                res_lo = '1;
            end else begin
                res_lo = neg_res ? ('0 - acc[XLEN-1:0]) : acc[XLEN-1:0];
                res_hi = neg_rem ? ('0 - acc[2*XLEN-1:XLEN]) : acc[2*XLEN-1:XLEN];
            end
        end
    end

    // Sequencer: issue/MTHI/MTLO in IDLE, XLEN steps in CALC, HI/LO write and done pulse in FIX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            count    <= '0;
            acc      <= '0;
            opb      <= '0;
            dividend <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start && !bus.flush) begin
                        if (bus.op <= MDU_DIVU) begin
                            count    <= '0;
                            acc      <= skip ? '0 : {{XLEN{1'b0}}, mag_a};
                            opb      <= mag_b;
                            dividend <= bus.rs_val;
                            is_div   <= op_div;
                            neg_res  <= sign_a ^ sign_b;
                            neg_rem  <= sign_a;
                            div_zero <= op_div && (bus.rt_val == '0);
                            state    <= skip ? ST_FIX : ST_CALC;
                        end else if (bus.op == MDU_MTHI) begin
                            hi_q <= bus.rs_val;
                        end else if (bus.op == MDU_MTLO) begin
                            lo_q <= bus.rs_val;
                        end
                    end
                end
                ST_CALC: begin
                    if (bus.flush) begin
                        state <= ST_IDLE;
                    end else begin
                        acc   <= acc_step;
                        count <= count + CNT_W'(1);
                        if (count == CNT_W'(XLEN - 1))
                            state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    if (!bus.flush) begin
                        hi_q   <= res_hi;
                        lo_q   <= res_lo;
                        done_q <= 1'b1;
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy = (state != ST_IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: doc/mdu_seq_ctrl.md
Name: mdu_seq_ctrl

Overview:
- Iterative multiply/divide sequencer for the MIPS datapath.
- Executes MULT/MULTU/DIV/DIVU over multiple cycles and owns the architectural HI/LO registers.
- Stalls the pipeline through a busy/done handshake.
- Sits beside the single-cycle ALU in EX. The pipeline reads HI/LO directly for MFHI/MFLO.

Parameters:
- XLEN, 32, operand/HI/LO width; iteration count equals XLEN.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  issue request; sampled only while idle.
- op  in  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6,7 reserved (no-op).
- rs_val  in  XLEN  operand A / dividend / MTHI-MTLO source.
- rt_val  in  XLEN  operand B / divisor.
- flush  in  1  abort the in-flight operation.
- busy  out  1  high while an operation is in flight; the pipeline stalls MDU-dependent instructions.
- done  out  1  one-cycle pulse when HI/LO update with a result.
- hi  out  XLEN  HI register.
- lo  out  XLEN  LO register.

Behaviour:
- One clock. Reset is asynchronous and active-low (rst_n). Reset drives state=IDLE, hi=0, lo=0, busy=0, done=0, and clears the counter.
- States: IDLE, CALC, FIX.
- IDLE:
  - start with op 0-3: latch operand magnitudes and sign flags, set count=0, go to CALC, busy=1 from the next cycle.
  - start with op 4/5: write hi/lo from rs_val at that edge. busy stays 0, done not pulsed.
  - Reserved op: ignored.
- CALC: one radix-2 step per cycle.
  - Multiply: shift-add into a 2*XLEN accumulator.
  - Divide: restoring shift-subtract, with remainder in the upper half and quotient in the lower half.
  - After XLEN steps (count=XLEN-1), go to FIX.
- FIX:
  - Apply the sign correction for signed ops:
    - Product is negated if the operand signs differ.
    - Quotient is negated if the signs differ.
    - Remainder takes the sign of the dividend.
  - Write hi/lo, pulse done, return to IDLE. busy falls in the same cycle done is high.
- Latency: start sampled at edge 0, result written at edge XLEN+1 (33), so busy is high for XLEN+1 cycles.
- Divide by zero, signed or unsigned: hi=dividend, lo=all ones. No trap.
- Signed overflow (0x80000000 / -1): lo=0x80000000, hi=0.
- start while busy: ignored. No queueing; the pipeline must hold the instruction.
- flush:
  - In CALC or FIX, flush returns to IDLE on the next edge. hi/lo are unchanged and done is not pulsed.
  - flush with start in IDLE on the same edge: flush wins and nothing is issued.
- Operands are captured at issue; later changes on rs_val/rt_val have no effect.
- Async reset mid-operation: immediate return to reset values. Partial results are discarded.

Optional Feature:
- Macro: MDU_ZERO_SKIP_EN.
- Defined: if either operand of a multiply is zero, or the divisor of a divide is zero, IDLE goes straight to FIX. The result is written at edge 1; busy is high for 1 cycle.
- Undefined: all multiply/divide ops take the full XLEN+1 cycles. Results are identical either way.

Decomposition:
- Shared package mips_pkg:
  - op encodings as localparams (MDU_MULT ... MDU_MTLO).
  - State encoding as a typedef enum.
  - XLEN default.
- One combinational sub-module, mdu_iter_step: a single multiply-add or divide-subtract step on the accumulator, selected by a mul/div flag. The FSM, counter, sign fix and HI/LO stay in the top module.

Test Plan:
- MULT rs=7, rt=0xFFFFFFFD (-3) -> done at cycle 33; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high cycles 1-33.
- MULTU rs=rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- Divide boundary cases:
  - DIVU rs=100, rt=0 -> hi=0x00000064, lo=0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
  - With MDU_ZERO_SKIP_EN, the divide-by-zero case completes at cycle 1.
- MTHI rs=0xA5A5A5A5, then MULT 3*4 with flush at cycle 10 -> hi=0xA5A5A5A5 retained, lo unchanged, no done, busy low from cycle 11.
- Control edge cases:
  - A second start during busy is ignored; only the first result appears.
  - Assert rst_n=0 at cycle 15 of a DIV -> hi=lo=0 and busy=0 immediately.
